// File: rtl/core_pkg.sv
// Shared miniRV core constants: writeback source selects, load funct3 codes
// and the default datapath width.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Load data extraction: picks a byte or halfword out of the aligned memory
// word and sign- or zero-extends it. Purely combinational.
module load_ext
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   ext_data = rdata;
      // reserved encodings pass the raw word through
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback-data formation for miniRV.
// Optional retired-instruction counter enabled by `define MEM_WB_INSTRET_EN.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic [XLEN-1:0]    mem_pc,
  input  logic               mem_rf_we,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [1:0]         mem_wb_sel,
  input  logic [2:0]         mem_funct3,
  input  logic [1:0]         mem_addr_lo,
  input  logic [XLEN-1:0]    mem_alu_res,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic [XLEN-1:0]    mem_imm,
  output logic               wb_valid,
  output logic [XLEN-1:0]    wb_pc,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [XLEN-1:0]    wb_wdata,
  output logic [63:0]        instret
);

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wdata_next;
  logic            we_next;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3   (mem_funct3),
    .addr_lo  (mem_addr_lo),
    .rdata    (mem_rdata),
    .ext_data (load_data)
  );

  always_comb begin
    case (mem_wb_sel)
      WB_SEL_ALU:  wdata_next = mem_alu_res;
      WB_SEL_LOAD: wdata_next = load_data;
      WB_SEL_PC4:  wdata_next = mem_pc + XLEN'(4);
      default:     wdata_next = mem_imm;
    endcase
    // x0 is hardwired zero, so a write to it is suppressed at capture
    we_next = mem_valid & mem_rf_we & (mem_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_pc    <= '0;
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= mem_valid;
      wb_pc    <= mem_pc;
      wb_we    <= we_next;
      wb_waddr <= mem_rd;
      wb_wdata <= wdata_next;
    end
  end

`ifdef MEM_WB_INSTRET_EN
  logic [63:0] instret_q;

  // counts the instruction leaving WB; a stalled WB slot is not yet retired
  always_ff @(posedge clk) begin
    if (!rst_n)
      instret_q <= '0;
    else if (wb_valid && !stall)
      instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic against a behavioural model of the MEM/WB register.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        mem_valid, mem_rf_we;
  logic [31:0] mem_pc, mem_alu_res, mem_rdata, mem_imm;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel, mem_addr_lo;
  logic [2:0]  mem_funct3;
  logic        wb_valid, wb_we;
  logic [31:0] wb_pc, wb_wdata;
  logic [4:0]  wb_waddr;
  logic [63:0] instret;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        m_valid = 1'b0, m_we = 1'b0;
  logic [31:0] m_pc = '0, m_wdata = '0;
  logic [4:0]  m_waddr = '0;
  logic [63:0] m_instret = '0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_rf_we(mem_rf_we),
    .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_addr_lo(mem_addr_lo), .mem_alu_res(mem_alu_res),
    .mem_rdata(mem_rdata), .mem_imm(mem_imm),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .instret(instret)
  );

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata();
    case (mem_wb_sel)
      2'd0:    return mem_alu_res;
      2'd1:    return ref_load(mem_funct3, mem_addr_lo, mem_rdata);
      2'd2:    return 32'((64'(mem_pc) + 64'd4) % 64'h1_0000_0000);
      default: return mem_imm;
    endcase
  endfunction

  // Advance one clock: update the model from the current inputs, then sample
  // the DUT 1 ns after the edge.
  task automatic tick();
    if (!rst_n) begin
      m_valid = 0; m_we = 0; m_pc = 0; m_waddr = 0; m_wdata = 0; m_instret = 0;
    end else begin
`ifdef MEM_WB_INSTRET_EN
      if (m_valid && !stall) m_instret = m_instret + 64'd1;
`endif
      if (flush) begin
        m_valid = 0; m_we = 0;
      end else if (!stall) begin
        m_valid = mem_valid;
        m_we    = mem_valid && mem_rf_we && (mem_rd != 0);
        m_waddr = mem_rd;
        m_pc    = mem_pc;
        m_wdata = ref_wdata();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu);
    mem_valid = v; mem_rf_we = we; mem_rd = rd; mem_wb_sel = sel; mem_alu_res = alu;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0;
    drive(1, 1, 5, 2'd0, 32'hDEAD_BEEF);
    mem_pc = 32'h100; mem_imm = 32'h1; mem_rdata = 32'h2; mem_funct3 = 3'd2; mem_addr_lo = 0;
    tick(); tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
    n_cmp++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", wb_we); end
    n_cmp++; if (wb_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", wb_waddr); end
    n_cmp++; if (wb_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", wb_wdata); end
    n_cmp++; if (wb_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", wb_pc); end
    n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    rst_n = 1;
    tick();
    n_cmp++; if (wb_we !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL first_capture: got we=%b rd=%0d data=%h expected we=1 rd=5 data=deadbeef", wb_we, wb_waddr, wb_wdata); end
  endtask

  task automatic test_alu_x0();
    drive(1, 1, 3, 2'd0, 32'h1234_5678);
    tick();
    n_cmp++; if (wb_we !== 1'b1 || wb_waddr !== 5'd3 || wb_wdata !== 32'h1234_5678)
      begin n_fail++; $display("FAIL alu_wb: got we=%b rd=%0d data=%h expected we=1 rd=3 data=12345678", wb_we, wb_waddr, wb_wdata); end
    drive(1, 1, 0, 2'd0, 32'h1234_5678);
    tick();
    n_cmp++; if (wb_we !== 1'b0 || wb_valid !== 1'b1)
      begin n_fail++; $display("FAIL x0_protect: got we=%b valid=%b expected we=0 valid=1", wb_we, wb_valid); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  los  [5] = '{2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] exps [5] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_80F1, 32'h0000_7F01, 32'h80F1_7F01};
    mem_rdata = 32'h80F1_7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'(i + 10), 2'd1, 32'hFFFF_FFFF);
      mem_funct3 = f3s[i]; mem_addr_lo = los[i];
      tick();
      n_cmp++; if (wb_wdata !== exps[i])
        begin n_fail++; $display("FAIL load_%0d f3=%b lo=%0d: got %h expected %h", i, f3s[i], los[i], wb_wdata, exps[i]); end
    end
  endtask

  task automatic test_pc4_imm();
    drive(1, 1, 9, 2'd2, 32'h0);
    mem_pc = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (wb_wdata !== 32'h0 || wb_pc !== 32'hFFFF_FFFC)
      begin n_fail++; $display("FAIL pc4_wrap: got data=%h pc=%h expected data=0 pc=fffffffc", wb_wdata, wb_pc); end
    drive(1, 1, 9, 2'd3, 32'h0);
    mem_imm = 32'hABCD_E000;
    tick();
    n_cmp++; if (wb_wdata !== 32'hABCD_E000)
      begin n_fail++; $display("FAIL imm_wb: got %h expected abcde000", wb_wdata); end
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 7, 2'd0, 32'hA);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'($urandom_range(1, 31)), 2'd0, $urandom);
      tick();
      n_cmp++; if (wb_we !== 1'b1 || wb_waddr !== 5'd7 || wb_wdata !== 32'hA)
        begin n_fail++; $display("FAIL stall_hold_%0d: got we=%b rd=%0d data=%h expected we=1 rd=7 data=a", i, wb_we, wb_waddr, wb_wdata); end
    end
    flush = 1;
    tick();
    n_cmp++; if (wb_valid !== 1'b0 || wb_we !== 1'b0)
      begin n_fail++; $display("FAIL stall_flush: got valid=%b we=%b expected 0 0", wb_valid, wb_we); end
    stall = 0; flush = 0;
  endtask

  task automatic test_instret();
    logic [63:0] want;
    rst_n = 0; drive(0, 0, 0, 2'd0, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 5'(i + 1), 2'd0, 32'(i));
      if (i == 3 || i == 6) begin
        stall = 1; tick(); stall = 0;
      end
      flush = (i == 5);
      tick();
      flush = 0;
    end
    drive(0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) tick();
`ifdef MEM_WB_INSTRET_EN
    want = 64'd9;
`else
    want = 64'd0;
`endif
    n_cmp++; if (instret !== want)
      begin n_fail++; $display("FAIL instret_count: got %0d expected %0d", instret, want); end
    n_cmp++; if (instret !== m_instret)
      begin n_fail++; $display("FAIL instret_model: got %0d expected %0d", instret, m_instret); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      stall       = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      mem_valid   = ($urandom_range(0, 4) != 0);
      mem_rf_we   = ($urandom_range(0, 3) != 0);
      mem_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      mem_wb_sel  = 2'($urandom);
      mem_funct3  = 3'($urandom);
      mem_addr_lo = 2'($urandom);
      mem_pc      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      mem_alu_res = $urandom;
      mem_rdata   = $urandom;
      mem_imm     = $urandom;
      tick();
      n_cmp++; if (wb_valid !== m_valid || wb_we !== m_we || wb_waddr !== m_waddr ||
                   wb_wdata !== m_wdata || wb_pc !== m_pc || instret !== m_instret)
        begin
          n_fail++;
          $display("FAIL random_%0d: got v=%b we=%b rd=%0d d=%h pc=%h ir=%0d expected v=%b we=%b rd=%0d d=%h pc=%h ir=%0d",
                   i, wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc, instret,
                   m_valid, m_we, m_waddr, m_wdata, m_pc, m_instret);
        end
      n_cmp++; if (wb_we === 1'b1 && wb_waddr === 5'd0)
        begin n_fail++; $display("FAIL random_x0_%0d: got we=1 waddr=0 expected no x0 write", i); end
    end
    rst_n = 1; stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_alu_x0();
    test_loads();
    test_pc4_imm();
    test_stall_flush();
    test_instret();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback-data formation for the 5-stage miniRV core.
- Captures memory-stage results and extracts/sign-extends load data.
- Selects the writeback source and drives the register file's write port (we/waddr/wdata) from registered state.
- Also exports the same registered values as the WB forwarding source for the hazard/forward unit.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk  input  1  core clock, all state updates on posedge
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- stall  input  1  hazard unit: hold current WB contents
- flush  input  1  hazard unit: kill the instruction being captured
- mem_valid  input  1  MEM stage holds a real instruction
- mem_pc  input  XLEN  PC of MEM instruction
- mem_rf_we  input  1  instruction writes rd
- mem_rd  input  RADDR_W  destination register
- mem_wb_sel  input  2  00 ALU, 01 LOAD, 10 PC+4, 11 IMM
- mem_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- mem_addr_lo  input  2  low bits of load address
- mem_alu_res  input  XLEN  ALU result
- mem_rdata  input  XLEN  raw aligned word from data memory
- mem_imm  input  XLEN  immediate (lui)
- wb_valid  output  1  WB holds a real instruction
- wb_pc  output  XLEN  PC of WB instruction (debug/trace)
- wb_we  output  1  regfile write enable
- wb_waddr  output  RADDR_W  regfile write address
- wb_wdata  output  XLEN  regfile write data
- instret  output  64  retired-instruction count (see Optional Feature)

Behaviour:
- Reset: when rst_n=0 at posedge, all output registers clear to 0: wb_valid, wb_pc, wb_we, wb_waddr, wb_wdata, and instret.
- Reset overrides stall and flush.
- Priority each posedge: reset > flush > stall > normal capture.
- Flush: wb_valid and wb_we clear to 0. Other fields are don't-care; they are implemented as held.
- Stall (no flush): all registers hold their values. wb_we stays at its held value; a duplicate write of identical data is harmless and is permitted.
- Normal capture: registers load next-state values.
  - wb_valid = mem_valid.
  - wb_we = mem_valid & mem_rf_we & (mem_rd != 0).
  - wb_waddr = mem_rd.
  - wb_pc = mem_pc.
  - wb_wdata = selected data.
- Latency: one cycle from MEM inputs to wb_* outputs. The regfile commits on the following posedge.
- wb_sel selection:
  - ALU: mem_alu_res.
  - LOAD: extracted load value.
  - PC+4: mem_pc + 4, modulo 2^XLEN; 0xFFFFFFFC wraps to 0.
  - IMM: mem_imm.
- Load extraction:
  - lb/lbu select byte mem_addr_lo (00 = bits 7:0 … 11 = bits 31:24). lb sign-extends bit 7 of that byte; lbu zero-extends.
  - lh/lhu select halfword mem_addr_lo[1] (0 = bits 15:0, 1 = bits 31:16); mem_addr_lo[0] is ignored. lh sign-extends; lhu zero-extends.
  - lw ignores mem_addr_lo.
  - Undefined funct3 (011, 110, 111) yields the raw mem_rdata.
- x0 protection: wb_we is never 1 with wb_waddr=0.
- All outputs are registered. No combinational path from any input to any output.

Optional Feature:
- Macro: MEM_WB_INSTRET_EN.
- Defined: 64-bit counter increments by 1 on each posedge where wb_valid=1 and stall=0, after reset. It wraps from 2^64-1 to 0.
- Undefined: instret is tied to 0 and no counter flops are synthesized.

Decomposition:
- Package core_pkg holds:
  - WB_SEL_ALU/LOAD/PC4/IMM localparams.
  - F3_LB/LH/LW/LBU/LHU constants.
  - XLEN default.
- One natural sub-module: load_ext, purely combinational, taking funct3, addr_lo and rdata and producing the extended value. Instantiated once, ahead of the writeback mux.

Test Plan:
- Reset: hold rst_n=0 two cycles with mem_valid=1, mem_rf_we=1, mem_rd=5 -> all outputs 0. First capture occurs at the first posedge with rst_n=1.
- ALU writeback and x0: mem_rd=3, ALU result 0x12345678 -> next cycle wb_we=1, wb_waddr=3, wb_wdata=0x12345678. Same with mem_rd=0 -> wb_we=0.
- Loads with mem_rdata=0x80F17F01:
  - lb addr_lo=2 -> 0xFFFFFFF1.
  - lbu addr_lo=2 -> 0x000000F1.
  - lh addr_lo=3 -> 0xFFFF80F1.
  - lhu addr_lo=0 -> 0x00007F01.
  - lw -> 0x80F17F01.
- PC+4 and IMM: wb_sel=10 with mem_pc=0xFFFFFFFC -> wb_wdata=0x00000000. wb_sel=11 with mem_imm=0xABCDE000 -> 0xABCDE000.
- Stall/flush: capture rd=7 data 0xA, then stall 3 cycles with changing inputs -> outputs hold rd=7/0xA. Assert stall and flush together -> wb_valid=0, wb_we=0.
- MEM_WB_INSTRET_EN: 10 valid instructions, 2 stall cycles and 1 flush -> instret=9 when the flushed slot was one of the 10. With the macro undefined, instret stays 0.
